// File: rtl/tow_pkg.sv
// Shared codes for the tug-of-war score tracker and its match controller:
// display modes, FSM states, winner codes and rope limits.
package tow_pkg;

    localparam logic [1:0] LEDS_OFF   = 2'd0;
    localparam logic [1:0] LEDS_SN    = 2'd1;
    localparam logic [1:0] LEDS_SCORE = 2'd2;
    localparam logic [1:0] LEDS_ON    = 2'd3;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_DARK  = 2'd1,
        S_PLAY  = 2'd2,
        S_WON   = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_LEFT  = 2'd1;
    localparam logic [1:0] WIN_RIGHT = 2'd2;

    localparam logic [2:0] POS_CENTRE = 3'd3;
    localparam logic [2:0] POS_MAX    = 3'd6;

endpackage

// File: rtl/pb_edge.sv
// Rising-edge detector for a synchronous push-button level: one-cycle press
// per low-to-high transition.
module pb_edge (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic press
);

    logic pb_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pb_p0 <= 1'b0;
        else      pb_p0 <= pb;
    end

    assign press = pb & ~pb_p0;

endmodule

// File: rtl/score_tracker.sv
// Tug-of-war round tracker: rope position, foul detection, winner and LED bar.
// Define SCORE_TALLY_EN to add saturating per-player round tallies.
module score_tracker
    import tow_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic       leds_on,
    input  logic       clear,
    input  logic [1:0] leds_ctrl,
    output logic       winrnd,
    output logic [1:0] winner,
    output logic [6:0] leds,
    output logic [3:0] tally_l,
    output logic [3:0] tally_r
);

    function automatic logic [6:0] led_map(input logic en, input logic [1:0] mode,
                                           input logic [2:0] p);
        logic [6:0] v;
        v = '0;
        if (en) begin
            case (mode)
                LEDS_SN:    v = 7'b1010101;
                LEDS_ON:    v = 7'b1111111;
                LEDS_SCORE: v = 7'b0000001 << p;
                default:    v = '0;
            endcase
        end
        return v;
    endfunction

    logic       press_l, press_r, press_l_v, press_r_v;
    state_t     state_q, state_d;
    logic [2:0] pos_q, pos_d, pos_inc, pos_dec;
    logic [1:0] winner_q, winner_d;
    logic       winrnd_q, clear_p0;
    logic [6:0] leds_q;

    pb_edge u_edge_l (.clk(clk), .rst(rst), .pb(pb_l), .press(press_l));
    pb_edge u_edge_r (.clk(clk), .rst(rst), .pb(pb_r), .press(press_r));

    // Simultaneous presses cancel each other out.
    assign press_l_v = press_l & ~press_r;
    assign press_r_v = press_r & ~press_l;
    assign pos_inc   = pos_q + 3'd1;
    assign pos_dec   = pos_q - 3'd1;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        winner_d = WIN_NONE;
        case (state_q)
            S_CLEAR: begin
                if (!clear && !leds_on) state_d = S_DARK;
            end
            S_DARK: begin
                if (clear) begin
                    state_d = S_CLEAR;
                end else if (press_l_v) begin
                    state_d  = S_WON;
                    winner_d = WIN_RIGHT;
                end else if (press_r_v) begin
                    state_d  = S_WON;
                    winner_d = WIN_LEFT;
                end else if (leds_on && leds_ctrl == LEDS_SCORE) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (clear) begin
                    state_d = S_CLEAR;
                end else if (press_l_v) begin
                    pos_d = pos_inc;
                    if (pos_inc == POS_MAX) begin
                        state_d  = S_WON;
                        winner_d = WIN_LEFT;
                    end
                end else if (press_r_v) begin
                    pos_d = pos_dec;
                    if (pos_dec == 3'd0) begin
                        state_d  = S_WON;
                        winner_d = WIN_RIGHT;
                    end
                end
            end
            S_WON: begin
                // Clear is held while gloating; the round ends on its release.
                winner_d = winner_q;
                if (clear_p0 && !clear) begin
                    state_d  = S_DARK;
                    winner_d = WIN_NONE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
        if (state_d == S_CLEAR || state_d == S_DARK) pos_d = POS_CENTRE;
    end

    // Registered state, rope position, winner and display
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_CLEAR;
            pos_q    <= POS_CENTRE;
            winner_q <= WIN_NONE;
            winrnd_q <= 1'b0;
            clear_p0 <= 1'b0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            winner_q <= winner_d;
            winrnd_q <= (state_d == S_WON) && (state_q != S_WON);
            clear_p0 <= clear;
            leds_q   <= led_map(leds_on, leds_ctrl, pos_q);
        end
    end

    assign winrnd = winrnd_q;
    assign winner = winner_q;
    assign leds   = leds_q;

`ifdef SCORE_TALLY_EN
    logic [3:0] tally_l_q, tally_r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tally_l_q <= '0;
            tally_r_q <= '0;
        end else if (winrnd_q) begin
            if (winner_q == WIN_LEFT && tally_l_q != 4'hF)  tally_l_q <= tally_l_q + 4'd1;
            if (winner_q == WIN_RIGHT && tally_r_q != 4'hF) tally_r_q <= tally_r_q + 4'd1;
        end
    end

    assign tally_l = tally_l_q;
    assign tally_r = tally_r_q;
`else
    assign tally_l = '0;
    assign tally_r = '0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed scoreboard bench for score_tracker: expectations are queued as
// stimulus is driven and checked one cycle later.
module tb_score_tracker;
    import tow_pkg::*;

    logic       clk, rst, pb_l, pb_r, leds_on, clear;
    logic [1:0] leds_ctrl;
    logic       winrnd;
    logic [1:0] winner;
    logic [6:0] leds;
    logic [3:0] tally_l, tally_r;

    score_tracker dut (
        .clk(clk), .rst(rst), .pb_l(pb_l), .pb_r(pb_r), .leds_on(leds_on),
        .clear(clear), .leds_ctrl(leds_ctrl), .winrnd(winrnd), .winner(winner),
        .leds(leds), .tally_l(tally_l), .tally_r(tally_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SCORE_TALLY_EN
    localparam bit TALLY_ON = 1'b1;
`else
    localparam bit TALLY_ON = 1'b0;
`endif

    localparam int SEL_WINRND = 0, SEL_WINNER = 1, SEL_LEDS = 2, SEL_POS = 3,
                   SEL_STATE = 4, SEL_TL = 5, SEL_TR = 6;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_WINRND: return {7'b0, winrnd};
            SEL_WINNER: return {6'b0, winner};
            SEL_LEDS:   return {1'b0, leds};
            SEL_POS:    return {5'b0, dut.pos_q};
            SEL_STATE:  return {6'b0, dut.state_q};
            SEL_TL:     return {4'b0, tally_l};
            SEL_TR:     return {4'b0, tally_r};
            default:    return 8'hFF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_checks++;
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic left_round();
        step();
        for (int i = 0; i < 2; i++) begin
            pb_l = 1'b1; step();
            pb_l = 1'b0; step();
        end
        pb_l = 1'b1;
        expect_v("tally_round_winrnd", SEL_WINRND, 8'd1);
        expect_v("tally_round_winner", SEL_WINNER, 8'(WIN_LEFT));
        step();
        pb_l  = 1'b0; step();
        clear = 1'b1; step();
        clear = 1'b0; step();
    endtask

    initial begin
        rst = 1'b0; pb_l = 1'b0; pb_r = 1'b0; leds_on = 1'b0; clear = 1'b0;
        leds_ctrl = LEDS_OFF;
        step(); step();

        expect_v("rst_state",  SEL_STATE,  8'(S_CLEAR));
        expect_v("rst_pos",    SEL_POS,    8'd3);
        expect_v("rst_winrnd", SEL_WINRND, 8'd0);
        expect_v("rst_winner", SEL_WINNER, 8'd0);
        expect_v("rst_leds",   SEL_LEDS,   8'd0);
        expect_v("rst_tl",     SEL_TL,     8'd0);
        expect_v("rst_tr",     SEL_TR,     8'd0);
        step();

        // Left wins
        rst = 1'b1; clear = 1'b1;
        expect_v("clear_hold", SEL_STATE, 8'(S_CLEAR));
        step();
        clear = 1'b0;
        expect_v("to_dark", SEL_STATE, 8'(S_DARK));
        expect_v("dark_pos", SEL_POS, 8'd3);
        step();
        leds_on = 1'b1; leds_ctrl = LEDS_SCORE;
        expect_v("to_play", SEL_STATE, 8'(S_PLAY));
        expect_v("leds_centre", SEL_LEDS, 8'h08);
        step();
        pb_l = 1'b1;
        expect_v("left1_pos", SEL_POS, 8'd4);
        expect_v("left1_winrnd", SEL_WINRND, 8'd0);
        step();
        pb_l = 1'b0;
        expect_v("leds_pos4", SEL_LEDS, 8'h10);
        step();
        pb_l = 1'b1;
        expect_v("left2_pos", SEL_POS, 8'd5);
        step();
        pb_l = 1'b0; step();
        pb_l = 1'b1;
        expect_v("left3_pos", SEL_POS, 8'd6);
        expect_v("left3_state", SEL_STATE, 8'(S_WON));
        expect_v("left3_winrnd", SEL_WINRND, 8'd1);
        expect_v("left3_winner", SEL_WINNER, 8'(WIN_LEFT));
        step();
        pb_l = 1'b0;
        expect_v("winrnd_one_cycle", SEL_WINRND, 8'd0);
        expect_v("left_win_leds", SEL_LEDS, 8'h40);
        step();

        // Gloat: clear held, then released
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_v("gloat_winner", SEL_WINNER, 8'(WIN_LEFT));
            expect_v("gloat_leds",   SEL_LEDS,   8'h40);
            expect_v("gloat_state",  SEL_STATE,  8'(S_WON));
            expect_v("gloat_winrnd", SEL_WINRND, 8'd0);
            step();
        end
        clear = 1'b0; leds_ctrl = LEDS_SN;
        expect_v("gloat_end_winner", SEL_WINNER, 8'(WIN_NONE));
        expect_v("gloat_end_state",  SEL_STATE,  8'(S_DARK));
        expect_v("gloat_end_pos",    SEL_POS,    8'd3);
        step();

        // Foul: right press while dark
        pb_r = 1'b1;
        expect_v("foul_state",  SEL_STATE,  8'(S_WON));
        expect_v("foul_winrnd", SEL_WINRND, 8'd1);
        expect_v("foul_winner", SEL_WINNER, 8'(WIN_LEFT));
        expect_v("foul_pos",    SEL_POS,    8'd3);
        expect_v("sn_leds",     SEL_LEDS,   8'h55);
        step();
        pb_r = 1'b0;
        expect_v("foul_winrnd_end", SEL_WINRND, 8'd0);
        step();
        clear = 1'b1; step();
        clear = 1'b0;
        expect_v("foul_exit", SEL_STATE, 8'(S_DARK));
        step();

        // Simultaneous presses
        leds_ctrl = LEDS_SCORE;
        expect_v("sim_play", SEL_STATE, 8'(S_PLAY));
        step();
        pb_l = 1'b1; step();
        pb_l = 1'b0;
        expect_v("sim_pre_pos", SEL_POS, 8'd4);
        step();
        pb_l = 1'b1; pb_r = 1'b1;
        expect_v("sim_pos",    SEL_POS,    8'd4);
        expect_v("sim_winrnd", SEL_WINRND, 8'd0);
        expect_v("sim_state",  SEL_STATE,  8'(S_PLAY));
        step();
        pb_l = 1'b0; pb_r = 1'b0; step();

        // Abort at pos 5
        pb_l = 1'b1; step();
        pb_l = 1'b0;
        expect_v("abort_pre_pos", SEL_POS, 8'd5);
        step();
        clear = 1'b1;
        expect_v("abort_pos",    SEL_POS,    8'd3);
        expect_v("abort_state",  SEL_STATE,  8'(S_CLEAR));
        expect_v("abort_winrnd", SEL_WINRND, 8'd0);
        expect_v("abort_winner", SEL_WINNER, 8'(WIN_NONE));
        step();

        // Right wins down to pos 0
        clear = 1'b0; leds_on = 1'b0;
        expect_v("right_dark", SEL_STATE, 8'(S_DARK));
        step();
        leds_on = 1'b1; step();
        pb_r = 1'b1; step();
        pb_r = 1'b0;
        expect_v("right1_pos", SEL_POS, 8'd2);
        step();
        pb_r = 1'b1; step();
        pb_r = 1'b0; step();
        pb_r = 1'b1;
        expect_v("right3_pos",    SEL_POS,    8'd0);
        expect_v("right3_winrnd", SEL_WINRND, 8'd1);
        expect_v("right3_winner", SEL_WINNER, 8'(WIN_RIGHT));
        expect_v("right3_state",  SEL_STATE,  8'(S_WON));
        step();
        pb_r = 1'b0;
        expect_v("right_win_leds", SEL_LEDS, 8'h01);
        step();
        clear = 1'b1; step();
        clear = 1'b0; step();
        expect_v("pre_rst_tl", SEL_TL, TALLY_ON ? 8'd2 : 8'd0);
        expect_v("pre_rst_tr", SEL_TR, TALLY_ON ? 8'd1 : 8'd0);
        step();

        // Mid-round asynchronous reset
        for (int i = 0; i < 2; i++) begin
            pb_l = 1'b1; step();
            pb_l = 1'b0; step();
        end
        expect_v("midrst_pre_pos", SEL_POS, 8'd5);
        drain();
        rst = 1'b0;
        #1;
        expect_v("midrst_state",  SEL_STATE,  8'(S_CLEAR));
        expect_v("midrst_pos",    SEL_POS,    8'd3);
        expect_v("midrst_winrnd", SEL_WINRND, 8'd0);
        expect_v("midrst_winner", SEL_WINNER, 8'(WIN_NONE));
        expect_v("midrst_leds",   SEL_LEDS,   8'd0);
        expect_v("midrst_tl",     SEL_TL,     8'd0);
        drain();
        expect_v("midrst_hold_winrnd", SEL_WINRND, 8'd0);
        step();

        // Tally: 16 left wins
        rst = 1'b1; clear = 1'b0; leds_on = 1'b0;
        expect_v("tally_dark", SEL_STATE, 8'(S_DARK));
        step();
        leds_on = 1'b1; leds_ctrl = LEDS_SCORE;
        for (int r = 0; r < 16; r++) left_round();
        step();
        expect_v("tally_l_sat", SEL_TL, TALLY_ON ? 8'd15 : 8'd0);
        expect_v("tally_r_zero", SEL_TR, 8'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- pb_l  in  1  left-player button, synchronous level.
- pb_r  in  1  right-player button, synchronous level.
- leds_on  in  1  display enable from the match controller.
- clear  in  1  round-clear request from the match controller.
- leds_ctrl  in  2  display mode: off=0, sn=1, score=2, on=3.
- winrnd  out  1  one-cycle pulse, round decided.
- winner  out  2  none=0, left=1, right=2.
- leds  out  7  LED bar; bit 6 is the left end, bit 3 is the centre.
- tally_l  out  4  left rounds won.
- tally_r  out  4  right rounds won.

Function
REQ-002 The block SHALL rising-edge-detect pb_l and pb_r internally, producing a one-cycle press per low-to-high transition.
REQ-003 When both presses occur in the same cycle, the block SHALL ignore both.
REQ-004 Rope position pos SHALL be 3 bits, range 0..6, with centre value 3.
REQ-005 The FSM SHALL have exactly four states: S_CLEAR, S_DARK, S_PLAY and S_WON.
REQ-006 S_CLEAR SHALL go to S_DARK when clear=0 and leds_on=0.
REQ-007 S_DARK SHALL go to S_PLAY when clear=0, leds_on=1 and leds_ctrl=score.
REQ-008 S_DARK and S_PLAY SHALL go to S_CLEAR when clear=1 (abort).
REQ-009 S_WON SHALL ignore clear=1, and SHALL go to S_DARK on the falling edge of clear (registered clear=1, current clear=0).
REQ-010 pos SHALL be forced to 3 while in S_CLEAR or S_DARK.
REQ-011 In S_PLAY, a left press SHALL increment pos and a right press SHALL decrement pos.
REQ-012 In S_PLAY, when pos becomes 6, next state SHALL be S_WON with winner=left; when pos becomes 0, next state SHALL be S_WON with winner=right.
REQ-013 Foul rule: in S_DARK, a left press alone SHALL set winner=right and a right press alone SHALL set winner=left; either SHALL go to S_WON with pos unchanged.
REQ-014 winrnd SHALL be registered and SHALL pulse high for exactly one cycle on the cycle S_WON is entered.
REQ-015 winner SHALL hold its value in S_WON and SHALL return to none on leaving S_WON.
REQ-016 In S_WON, pos SHALL be frozen and all presses SHALL be ignored.
REQ-017 leds SHALL be registered with one-cycle latency. Mapping:
- leds_on=0 -> 0.
- off -> 0.
- sn -> 7'b1010101.
- on -> 7'b1111111.
- score -> one-hot bit pos.

Reset
REQ-018 While rst=0 the block SHALL hold: state=S_CLEAR, pos=3, winrnd=0, winner=none, leds=0, tally_l=0, tally_r=0, and cleared edge-detect history.
REQ-019 Reset asserted mid-round SHALL abort the round immediately, with no winrnd pulse.

Configuration
REQ-020 With SCORE_TALLY_EN defined, the block SHALL increment tally_l or tally_r on each winrnd pulse for the respective winner, saturating at 15; only rst clears them.
REQ-021 Without SCORE_TALLY_EN, the block SHALL include no tally registers and SHALL drive tally_l and tally_r to constant 0.

Structure
REQ-022 Package tow_pkg SHALL hold:
- the leds_ctrl code constants (off/sn/score/on);
- the FSM state enum;
- the winner codes;
- POS_CENTRE=3 and POS_MAX=6.
REQ-023 The match controller SHALL import tow_pkg for its leds_ctrl codes.
REQ-024 Edge detection SHALL be one sub-module, pb_edge, instantiated twice.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Left wins: rst released; clear=1 then clear=0 with leds_on=0; then leds_on=1, leds_ctrl=score; 3 left presses -> pos 4,5,6; winrnd one pulse on the cycle after the 3rd press; winner=1; leds=7'b1000000.
- Foul: in S_DARK, one right press -> winrnd pulse; winner=1 (left); pos stays 3.
- Simultaneous: in S_PLAY, pb_l and pb_r rise in the same cycle -> pos unchanged, no winrnd.
- Abort: in S_PLAY at pos=5, clear=1 -> pos=3 next cycle; state S_CLEAR; no winrnd.
- Gloat: after a win, clear=1 for 10 cycles -> winner held and leds unchanged; clear falls -> winner=0, state S_DARK.
- Tally (SCORE_TALLY_EN): 16 left wins -> tally_l=15, tally_r=0. Without the macro, the same stimulus -> both tallies 0.
